fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
Frame-level scheduler wrapped around the radix-4 FFT controller and its 4-bank RAM datapath. It accepts a 2048-sample input stream and writes it into the banks, then hands the memories to the FFT core and starts it. When the core reports ready, it streams the 2048 result bins out in natural bin order. It owns the memory-port mux select, so loader, FFT core and unloader never drive the banks at the same time.

Parameters:
A_BIT, 9, address width per bank (4 banks x 2^A_BIT = 2048 points)
RD_LAT, 2, RAM read latency in cycles from oUL_RE to data valid at the datapath output
ACK_TO, 4, cycles allowed for iFFT_RDY to fall after oFFT_START
REV_EN, 1, 1 = unload in digit-reversed memory order (natural bin order out); 0 = linear memory order

Ports:
iCLK  in  1  clock
iRESET  in  1  reset, asynchronous, active-low
iEN  in  1  frame enable; sampled only in IDLE
iIN_VALID  in  1  input sample valid
oIN_READY  out  1  scheduler accepts a sample this cycle
oLD_WE  out  1  load write strobe to RAM bank
oLD_BANK  out  2  load bank select
oLD_ADDR  out  A_BIT  load address
oFFT_START  out  1  one-cycle start pulse to the FFT controller
iFFT_RDY  in  1  FFT controller ready (1 = idle or done)
oMEM_OWN  out  1  0 = scheduler drives RAM ports; 1 = FFT core drives them
oUL_RE  out  1  unload read strobe
oUL_BANK  out  2  unload bank select
oUL_ADDR  out  A_BIT  unload address
oOUT_VALID  out  1  result bin valid at datapath output (oUL_RE delayed RD_LAT)
oOUT_SOP  out  1  qualifies bin 0
oOUT_EOP  out  1  qualifies bin 2047
oOUT_IDX  out  A_BIT+2  bin index of the current output
oBUSY  out  1  state != IDLE
oERR  out  1  sticky: start not acknowledged within ACK_TO cycles
oFRAME_CNT  out  8  completed frames, wraps at 255 -> 0

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately; the partial frame is lost.
- All outputs are registered.
- FSM states: IDLE, LOAD, START, WAIT_ACK, RUN, UNLOAD, DRAIN.
- IDLE -> LOAD when iEN=1. Deasserting iEN mid-frame does not abort; the frame completes and the FSM then stays in IDLE.
- LOAD:
  - oIN_READY = 1, decoded from the state register.
  - Accept = iIN_VALID & oIN_READY. 11-bit load count n increments per accept.
  - The cycle after an accept: oLD_WE=1, oLD_BANK=n[10:9], oLD_ADDR=n[8:0]. The datapath registers the sample with the accept.
  - The accept with n=2047 moves the FSM to START. oIN_READY is therefore 0 on the following cycle, and no 2049th sample is accepted.
  - Gaps in iIN_VALID are allowed; n holds during gaps.
- START: oFFT_START=1 for exactly one cycle, oMEM_OWN=1. Next state WAIT_ACK.
- WAIT_ACK:
  - iFFT_RDY=0 -> RUN.
  - If iFFT_RDY is still 1 after ACK_TO cycles: set oERR, set oMEM_OWN=0, return to IDLE. No frame count.
- RUN: oMEM_OWN=1. iFFT_RDY rising to 1 -> UNLOAD, with oMEM_OWN=0 from the next cycle.
- UNLOAD:
  - One read per cycle; 11-bit count k = 0..2047, no backpressure.
  - Memory index m = rev(k) if REV_EN, else m = k.
  - rev(k) = {k[1:0],k[3:2],k[5:4],k[7:6],k[9:8],k[10]}.
  - oUL_RE=1, oUL_BANK=m[10:9], oUL_ADDR=m[8:0].
  - After k=2047 -> DRAIN.
- DRAIN: wait RD_LAT cycles until the last oOUT_VALID, then increment oFRAME_CNT and go to IDLE.
- Output path:
  - oOUT_VALID, oOUT_IDX, oOUT_SOP, oOUT_EOP are oUL_RE, k, (k==0), (k==2047) delayed through an RD_LAT-deep shift register.
  - The shift register is cleared by reset only.
- oERR clears only on reset. A new frame may start with oERR=1.
- oLD_WE and oUL_RE are never 1 while oMEM_OWN=1.

Decomposition:
- Package fft_sched_pkg holds:
  - state enum (7 states, binary encoded)
  - N_POINT=2048, LOG2N=11, BANKS=4
  - rev() digit-reversal function
- Sub-module fft_out_delay: parameterised RD_LAT-deep valid/index/SOP/EOP shift register.

Test Plan:
1. Reset, iEN=1, 2048 back-to-back samples -> oLD_WE for n=0 shows bank0/addr0; n=1 bank0/addr1; n=512 bank1/addr0; n=2047 bank3/addr511. oIN_READY=0 the cycle after accept 2047. oFFT_START is a single pulse on the next cycle.
2. Random iIN_VALID gaps (50%) -> exactly 2048 oLD_WE pulses, with addresses contiguous and without duplicates.
3. FFT model drops iFFT_RDY 1 cycle after start and raises it after 6000 cycles -> oMEM_OWN=1 for that whole window. The first oUL_RE follows on the cycle after oMEM_OWN falls.
4. REV_EN=1 unload:
   - k=1 -> bank1/addr0; k=4 -> bank0/addr128; k=1024 -> bank0/addr1; k=2047 -> bank3/addr511.
   - oOUT_SOP appears 2 cycles after the first oUL_RE; oOUT_EOP on bin 2047.
   - oFRAME_CNT=1 after DRAIN.
5. iFFT_RDY held at 1 -> oERR=1 4 cycles after the WAIT_ACK entry, FSM returns to IDLE, oFRAME_CNT unchanged. The next frame proceeds normally.
6. Assert iRESET low mid-UNLOAD (k=700) -> all outputs 0 asynchronously. After release the FSM is in IDLE with oFRAME_CNT=0.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared types, sizes and the digit-reversal mapping for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int N_POINT = 2048;
    localparam int LOG2N   = 11;
    localparam int BANKS   = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_START    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RUN      = 3'd4,
        S_UNLOAD   = 3'd5,
        S_DRAIN    = 3'd6
    } sched_state_e;

    // Radix-4 digit reversal of an 11-bit bin index (five base-4 digits plus one leftover bit).
    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] k);
        rev = {k[1:0], k[3:2], k[5:4], k[7:6], k[9:8], k[10]};
    endfunction

endpackage

// File: rtl/fft_out_delay.sv
// Aligns the unload qualifiers (valid/index/SOP/EOP) with RAM read data,
// which appears RD_LAT cycles after the read strobe.
module fft_out_delay #(
    parameter int RD_LAT = 2,
    parameter int IW     = 11
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic          valid_i,
    input  logic [IW-1:0] idx_i,
    input  logic          sop_i,
    input  logic          eop_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic          sop_o,
    output logic          eop_o
);

    localparam int W = IW + 3;

    logic [W-1:0] pipe_q [RD_LAT];

    // Shift register; cleared only by reset so in-flight bins survive state changes.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {valid_i, sop_i, eop_i, idx_i};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {valid_o, sop_o, eop_o, idx_o} = pipe_q[RD_LAT-1];

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler: loads 2048 samples into the 4-bank RAM, hands the banks to the
// radix-4 FFT core, then streams the results out in natural bin order.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int A_BIT  = 9,
    parameter int RD_LAT = 2,
    parameter int ACK_TO = 4,
    parameter bit REV_EN = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iEN,
    input  logic             iIN_VALID,
    output logic             oIN_READY,
    output logic             oLD_WE,
    output logic [1:0]       oLD_BANK,
    output logic [A_BIT-1:0] oLD_ADDR,
    output logic             oFFT_START,
    input  logic             iFFT_RDY,
    output logic             oMEM_OWN,
    output logic             oUL_RE,
    output logic [1:0]       oUL_BANK,
    output logic [A_BIT-1:0] oUL_ADDR,
    output logic             oOUT_VALID,
    output logic             oOUT_SOP,
    output logic             oOUT_EOP,
    output logic [A_BIT+1:0] oOUT_IDX,
    output logic             oBUSY,
    output logic             oERR,
    output logic [7:0]       oFRAME_CNT
);

    localparam int IW = A_BIT + 2;
    localparam int BW = $clog2(BANKS);
    localparam int AW = $clog2(ACK_TO + 1);
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_POINT - 1);

    sched_state_e state_q, state_d;

    logic [IW-1:0]    n_q, n_d;
    logic [IW-1:0]    k_q, k_d;
    logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             ld_we_q, ld_we_d;
    logic [BW-1:0]    ld_bank_q, ld_bank_d;
    logic [A_BIT-1:0] ld_addr_q, ld_addr_d;
    logic             fft_start_q, fft_start_d;
    logic             mem_own_q, mem_own_d;
    logic             ul_re_q, ul_re_d;
    logic [BW-1:0]    ul_bank_q, ul_bank_d;
    logic [A_BIT-1:0] ul_addr_q, ul_addr_d;
    logic [IW-1:0]    ul_idx_q, ul_idx_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic             accept_s;
    logic             ack_timeout_s;
    logic             frame_done_s;
    logic             unload_s;
    logic [IW-1:0]    mem_idx_s;

    assign oIN_READY     = (state_q == S_LOAD);
    assign accept_s      = iIN_VALID & oIN_READY;
    assign ack_timeout_s = (state_q == S_WAIT_ACK) && iFFT_RDY && (ack_cnt_q == AW'(ACK_TO - 1));
    assign frame_done_s  = (state_q == S_DRAIN) && (drain_cnt_q == DW'(RD_LAT - 1));
    assign unload_s      = (state_q == S_UNLOAD);

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (iEN) state_d = S_LOAD; else state_d = S_IDLE;
            S_LOAD:     if (accept_s && (n_q == LAST_IDX)) state_d = S_START; else state_d = S_LOAD;
            S_START:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!iFFT_RDY) begin
                    state_d = S_RUN;
                end else if (ack_timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_RUN:      if (iFFT_RDY) state_d = S_UNLOAD; else state_d = S_RUN;
            S_UNLOAD:   if (k_q == LAST_IDX) state_d = S_DRAIN; else state_d = S_UNLOAD;
            S_DRAIN:    if (frame_done_s) state_d = S_IDLE; else state_d = S_DRAIN;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output and counter next values. Ownership follows the next state so the RAM
    // port hand-over lands one cycle after the last load write and before the first read.
    always_comb begin
        mem_idx_s   = REV_EN ? rev(k_q) : k_q;
        n_d         = accept_s ? n_q + IW'(1) : n_q;
        ld_we_d     = accept_s;
        ld_bank_d   = accept_s ? n_q[IW-1:A_BIT] : ld_bank_q;
        ld_addr_d   = accept_s ? n_q[A_BIT-1:0] : ld_addr_q;
        fft_start_d = (state_q == S_START);
        mem_own_d   = (state_d == S_WAIT_ACK) || (state_d == S_RUN);
        ack_cnt_d   = (state_q == S_WAIT_ACK) ? ack_cnt_q + AW'(1) : '0;
        k_d         = unload_s ? k_q + IW'(1) : '0;
        ul_re_d     = unload_s;
        ul_bank_d   = unload_s ? mem_idx_s[IW-1:A_BIT] : '0;
        ul_addr_d   = unload_s ? mem_idx_s[A_BIT-1:0] : '0;
        ul_idx_d    = unload_s ? k_q : '0;
        drain_cnt_d = (state_q == S_DRAIN) ? drain_cnt_q + DW'(1) : '0;
        busy_d      = (state_d != S_IDLE);
        err_d       = err_q | ack_timeout_s;
        frame_cnt_d = frame_done_s ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // Counters and registered outputs.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            n_q         <= '0;
            k_q         <= '0;
            ack_cnt_q   <= '0;
            drain_cnt_q <= '0;
            ld_we_q     <= 1'b0;
            ld_bank_q   <= '0;
            ld_addr_q   <= '0;
            fft_start_q <= 1'b0;
            mem_own_q   <= 1'b0;
            ul_re_q     <= 1'b0;
            ul_bank_q   <= '0;
            ul_addr_q   <= '0;
            ul_idx_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            n_q         <= n_d;
            k_q         <= k_d;
            ack_cnt_q   <= ack_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ld_we_q     <= ld_we_d;
            ld_bank_q   <= ld_bank_d;
            ld_addr_q   <= ld_addr_d;
            fft_start_q <= fft_start_d;
            mem_own_q   <= mem_own_d;
            ul_re_q     <= ul_re_d;
            ul_bank_q   <= ul_bank_d;
            ul_addr_q   <= ul_addr_d;
            ul_idx_q    <= ul_idx_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fft_out_delay #(
        .RD_LAT (RD_LAT),
        .IW     (IW)
    ) u_out_delay (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .valid_i (ul_re_q),
        .idx_i   (ul_idx_q),
        .sop_i   (ul_re_q && (ul_idx_q == '0)),
        .eop_i   (ul_re_q && (ul_idx_q == LAST_IDX)),
        .valid_o (oOUT_VALID),
        .idx_o   (oOUT_IDX),
        .sop_o   (oOUT_SOP),
        .eop_o   (oOUT_EOP)
    );

    assign oLD_WE     = ld_we_q;
    assign oLD_BANK   = ld_bank_q;
    assign oLD_ADDR   = ld_addr_q;
    assign oFFT_START = fft_start_q;
    assign oMEM_OWN   = mem_own_q;
    assign oUL_RE     = ul_re_q;
    assign oUL_BANK   = ul_bank_q;
    assign oUL_ADDR   = ul_addr_q;
    assign oBUSY      = busy_q;
    assign oERR       = err_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: load, FFT hand-over, digit-reversed unload,
// start timeout and mid-frame reset.
module tb_fft_frame_sched;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b0;
    logic        iEN = 1'b0;
    logic        iIN_VALID = 1'b0;
    logic        iFFT_RDY = 1'b1;
    logic        oIN_READY, oLD_WE, oFFT_START, oMEM_OWN, oUL_RE;
    logic        oOUT_VALID, oOUT_SOP, oOUT_EOP, oBUSY, oERR;
    logic [1:0]  oLD_BANK, oUL_BANK;
    logic [8:0]  oLD_ADDR, oUL_ADDR;
    logic [10:0] oOUT_IDX;
    logic [7:0]  oFRAME_CNT;
    logic [63:0] all_outs_s;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [10:0] wlog [2048];
    logic [10:0] ullog [2048];
    int          wcnt, last_wr_cyc, start_cyc, fall_cyc, own_bad;
    int          kcnt, ocnt, idx_bad, map_bad, first_re, sop_cyc, sop_n, eop_n, bad;
    logic        rdy_after_last, ul_at_fall;
    logic [10:0] eop_idx;

    always #5 iCLK = ~iCLK;

    fft_frame_sched dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iEN        (iEN),
        .iIN_VALID  (iIN_VALID),
        .oIN_READY  (oIN_READY),
        .oLD_WE     (oLD_WE),
        .oLD_BANK   (oLD_BANK),
        .oLD_ADDR   (oLD_ADDR),
        .oFFT_START (oFFT_START),
        .iFFT_RDY   (iFFT_RDY),
        .oMEM_OWN   (oMEM_OWN),
        .oUL_RE     (oUL_RE),
        .oUL_BANK   (oUL_BANK),
        .oUL_ADDR   (oUL_ADDR),
        .oOUT_VALID (oOUT_VALID),
        .oOUT_SOP   (oOUT_SOP),
        .oOUT_EOP   (oOUT_EOP),
        .oOUT_IDX   (oOUT_IDX),
        .oBUSY      (oBUSY),
        .oERR       (oERR),
        .oFRAME_CNT (oFRAME_CNT)
    );

    assign all_outs_s = {13'd0, oIN_READY, oLD_WE, oLD_BANK, oLD_ADDR, oFFT_START, oMEM_OWN,
                         oUL_RE, oUL_BANK, oUL_ADDR, oOUT_VALID, oOUT_SOP, oOUT_EOP, oOUT_IDX,
                         oBUSY, oERR, oFRAME_CNT};

    function automatic logic [10:0] rev_m(input logic [10:0] k);
        return {k[1:0], k[3:2], k[5:4], k[7:6], k[9:8], k[10]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    // Feed one frame of samples; returns on the cycle oFFT_START is seen.
    task automatic load_frame(input bit gaps);
        wcnt = 0; last_wr_cyc = -1; start_cyc = -1; rdy_after_last = 1'b1;
        iEN = 1'b1;
        iIN_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 7000 && start_cyc < 0; c++) begin
            tick();
            iEN = 1'b0;
            if (oLD_WE) begin
                if (wcnt < 2048) wlog[wcnt] = {oLD_BANK, oLD_ADDR};
                wcnt++;
                if (wcnt == 2048) begin
                    last_wr_cyc = cyc;
                    rdy_after_last = oIN_READY;
                end
            end
            if (oFFT_START) start_cyc = cyc;
            else iIN_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        iIN_VALID = 1'b0;
        check("start_seen", 64'(start_cyc >= 0), 64'd1);
        check("load_writes", 64'(wcnt), 64'd2048);
    endtask

    // FFT core model: drop ready one cycle after start, raise it after 'hold' cycles.
    task automatic run_fft(input int hold);
        tick();
        check("start_single_pulse", 64'(oFFT_START), 64'd0);
        iFFT_RDY = 1'b0;
        own_bad = 0;
        repeat (hold) begin
            tick();
            if (oMEM_OWN !== 1'b1 || oLD_WE !== 1'b0 || oUL_RE !== 1'b0) own_bad++;
        end
        iFFT_RDY = 1'b1;
        fall_cyc = -1;
        ul_at_fall = 1'b1;
        for (int c = 0; c < 20 && fall_cyc < 0; c++) begin
            tick();
            if (!oMEM_OWN) begin
                fall_cyc = cyc;
                ul_at_fall = oUL_RE;
            end else if (oUL_RE) begin
                own_bad++;
            end
        end
        check("mem_own_window", 64'(own_bad), 64'd0);
        check("mem_own_falls", 64'(fall_cyc >= 0), 64'd1);
        check("no_read_at_fall", 64'(ul_at_fall), 64'd0);
    endtask

    // Collect reads and output bins; stop_k >= 0 returns right after read k=stop_k.
    task automatic unload(input int stop_k);
        kcnt = 0; ocnt = 0; idx_bad = 0; map_bad = 0; first_re = -1;
        sop_cyc = -1; sop_n = 0; eop_n = 0; eop_idx = '0;
        for (int c = 0; c < 2200 && ocnt < 2048 && !(stop_k >= 0 && kcnt > stop_k); c++) begin
            tick();
            if (oUL_RE) begin
                if (first_re < 0) first_re = cyc;
                if (oMEM_OWN) map_bad++;
                if ({oUL_BANK, oUL_ADDR} !== rev_m(11'(kcnt))) map_bad++;
                if (kcnt < 2048) ullog[kcnt] = {oUL_BANK, oUL_ADDR};
                kcnt++;
            end
            if (oOUT_VALID) begin
                if (oOUT_IDX !== 11'(ocnt)) idx_bad++;
                if (oOUT_SOP) begin sop_n++; sop_cyc = cyc; end
                if (oOUT_EOP) begin eop_n++; eop_idx = oOUT_IDX; end
                ocnt++;
            end
        end
        check("first_read_after_fall", 64'(first_re - fall_cyc), 64'd1);
    endtask

    task automatic check_frame(input logic [7:0] exp_cnt);
        check("reads_total", 64'(kcnt), 64'd2048);
        check("bins_total", 64'(ocnt), 64'd2048);
        check("read_map", 64'(map_bad), 64'd0);
        check("bin_order", 64'(idx_bad), 64'd0);
        check("sop_count", 64'(sop_n), 64'd1);
        check("sop_latency", 64'(sop_cyc - first_re), 64'd2);
        check("eop_count", 64'(eop_n), 64'd1);
        check("eop_idx", 64'(eop_idx), 64'd2047);
        check("frame_cnt", 64'(oFRAME_CNT), 64'(exp_cnt));
        check("idle_after_drain", 64'(oBUSY), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_outputs", all_outs_s, 64'd0);
        iRESET = 1'b1;
        tick();
        check("idle_not_ready", 64'(oIN_READY), 64'd0);

        // Back-to-back frame, long FFT run, digit-reversed unload
        load_frame(1'b0);
        check("ld_n0", 64'(wlog[0]), 64'd0);
        check("ld_n1", 64'(wlog[1]), 64'd1);
        check("ld_n512_bank1", 64'(wlog[512]), 64'd512);
        check("ld_n2047_bank3", 64'(wlog[2047]), 64'd2047);
        check("ready_low_after_last", 64'(rdy_after_last), 64'd0);
        check("start_after_last_write", 64'(start_cyc - last_wr_cyc), 64'd1);
        run_fft(6000);
        unload(-1);
        check("ul_k1", 64'(ullog[1]), 64'd512);
        check("ul_k4", 64'(ullog[4]), 64'd128);
        check("ul_k1024", 64'(ullog[1024]), 64'd1);
        check("ul_k2047", 64'(ullog[2047]), 64'd2047);
        check_frame(8'd1);

        // Load with random valid gaps
        load_frame(1'b1);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (wlog[i] !== 11'(i)) bad++;
        end
        check("gap_load_contiguous", 64'(bad), 64'd0);
        run_fft(20);
        unload(-1);
        check_frame(8'd2);

        // Start never acknowledged
        load_frame(1'b0);
        repeat (3) tick();
        check("err_before_timeout", 64'(oERR), 64'd0);
        check("own_before_timeout", 64'(oMEM_OWN), 64'd1);
        tick();
        check("err_at_timeout", 64'(oERR), 64'd1);
        check("own_released_timeout", 64'(oMEM_OWN), 64'd0);
        check("idle_after_timeout", 64'(oBUSY), 64'd0);
        check("cnt_after_timeout", 64'(oFRAME_CNT), 64'd2);
        load_frame(1'b0);
        run_fft(20);
        unload(-1);
        check_frame(8'd3);
        check("err_sticky", 64'(oERR), 64'd1);

        // Reset during unload
        load_frame(1'b0);
        run_fft(20);
        unload(700);
        check("reads_before_reset", 64'(kcnt), 64'd701);
        iRESET = 1'b0;
        #2;
        check("async_reset_outputs", all_outs_s, 64'd0);
        tick();
        iRESET = 1'b1;
        tick();
        check("idle_after_reset", 64'(oBUSY), 64'd0);
        check("cnt_cleared", 64'(oFRAME_CNT), 64'd0);
        check("err_cleared", 64'(oERR), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
